// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types, constants and PC helpers for the instruction-fetch stage
//
// Contents:
//   fetch_state_e    : fetch FSM state encoding (IDLE, REQ, WAIT, HOLD, KILL)
//   NOP_INST         : addi x0,x0,0, also the reset value of the downstream ID/EX register
//   DEFAULT_RESET_PC : PC fetched first after reset unless overridden
//   align_pc/next_pc : word alignment and modulo-2^32 sequential increment
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_KILL = 3'd4
    } fetch_state_e;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Instruction memory is word addressed; low address bits are never issued.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // Plain 32-bit add: 32'hFFFF_FFFC rolls over to 0.
    function automatic logic [31:0] next_pc(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - control, instruction-memory and IF/ID signal bundle of the fetch stage
//
// Signals:
//   stall, redirect, redirect_pc        : hazard unit / EX into fetch
//   imem_req, imem_addr                 : request to instruction memory (fetch drives)
//   imem_ready, imem_rvalid, imem_rdata : accept and response from instruction memory
//   out_P_PC, out_inst, out_valid       : IF/ID register contents toward decode
// Modports:
//   master : the fetch stage
//   slave  : its environment (memory, hazard unit, EX, decode)
interface fetch_stage_if;

    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic [31:0] out_P_PC;
    logic [31:0] out_inst;
    logic        out_valid;

    modport master (
        input  stall, redirect, redirect_pc,
        input  imem_ready, imem_rvalid, imem_rdata,
        output imem_req, imem_addr,
        output out_P_PC, out_inst, out_valid
    );

    modport slave (
        output stall, redirect, redirect_pc,
        output imem_ready, imem_rvalid, imem_rdata,
        input  imem_req, imem_addr,
        input  out_P_PC, out_inst, out_valid
    );

endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// rtl/fetch_stage_ifid_reg.sv - IF/ID pipeline register with flush/hold/load/bubble priority
//
// Ports:
//   clk, rst             : clock, asynchronous active-low reset
//   flush                : redirect from EX, loads a NOP bubble (wins over hold)
//   hold                 : stall from the hazard unit, keeps current contents
//   load                 : fetch delivers load_inst tagged with load_pc
//   out_P_PC/inst/valid  : registered contents toward decode
module ifid_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] NOP_INST = fetch_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        hold,
    input  logic        load,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_inst,
    output logic [31:0] out_P_PC,
    output logic [31:0] out_inst,
    output logic        out_valid
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_P_PC  <= 32'h0;
            out_inst  <= NOP_INST;
            out_valid <= 1'b0;
        end else if (flush) begin
            out_P_PC  <= 32'h0;
            out_inst  <= NOP_INST;
            out_valid <= 1'b0;
        end else if (hold) begin
            out_P_PC  <= out_P_PC;
            out_inst  <= out_inst;
            out_valid <= out_valid;
        end else if (load) begin
            out_P_PC  <= load_pc;
            out_inst  <= load_inst;
            out_valid <= 1'b1;
        end else begin
            // Nothing delivered and decode is moving: hand it a bubble.
            out_P_PC  <= 32'h0;
            out_inst  <= NOP_INST;
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, single-outstanding imem requests, IF/ID register
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : fetch_stage_if.master (stall/redirect in, imem request/response, IF/ID out)
// Parameters:
//   RESET_PC : first PC fetched after reset
//   NOP_INST : word placed in IF/ID on flush or bubble
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INST = fetch_pkg::NOP_INST
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);

    localparam logic [2:0] S_IDLE = ST_IDLE;
    localparam logic [2:0] S_REQ  = ST_REQ;
    localparam logic [2:0] S_WAIT = ST_WAIT;
    localparam logic [2:0] S_HOLD = ST_HOLD;
    localparam logic [2:0] S_KILL = ST_KILL;

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_q, hold_d;
    logic        deliver;
    logic [31:0] deliver_inst;
    logic [31:0] redirect_tgt;

    assign redirect_tgt = align_pc(bus.redirect_pc);

    // pc always names the instruction currently being fetched (or the
    // redirect target once EX has spoken), so a delivery tags IF/ID with
    // pc and only then steps it.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_d       = hold_q;
        deliver      = 1'b0;
        deliver_inst = bus.imem_rdata;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (bus.redirect) begin
                    pc_d = redirect_tgt;
                end
            end
            S_REQ: begin
                if (bus.redirect) begin
                    pc_d = redirect_tgt;
                    // An accept in the redirect cycle is already wrong-path.
                    if (bus.imem_ready) begin
                        state_d = S_KILL;
                    end
                end else if (bus.imem_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.redirect) begin
                    pc_d    = redirect_tgt;
                    // A response in the same cycle closes the old request;
                    // otherwise it is still in flight and must be swallowed.
                    state_d = bus.imem_rvalid ? S_REQ : S_KILL;
                end else if (bus.imem_rvalid) begin
                    if (!bus.stall) begin
                        deliver = 1'b1;
                        pc_d    = next_pc(pc_q);
                        state_d = S_REQ;
                    end else begin
                        hold_d  = bus.imem_rdata;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (bus.redirect) begin
                    pc_d    = redirect_tgt;
                    state_d = S_REQ;
                end else if (!bus.stall) begin
                    deliver      = 1'b1;
                    deliver_inst = hold_q;
                    pc_d         = next_pc(pc_q);
                    state_d      = S_REQ;
                end
            end
            S_KILL: begin
                if (bus.redirect) begin
                    pc_d = redirect_tgt;
                end
                if (bus.imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            hold_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
        end
    end

    assign bus.imem_req  = (state_q == S_REQ);
    assign bus.imem_addr = pc_q;

    ifid_reg #(
        .NOP_INST (NOP_INST)
    ) u_ifid_reg (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.redirect),
        .hold      (bus.stall),
        .load      (deliver),
        .load_pc   (pc_q),
        .load_inst (deliver_inst),
        .out_P_PC  (bus.out_P_PC),
        .out_inst  (bus.out_inst),
        .out_valid (bus.out_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage: vector table, reset corner, random vs reference model
module tb_fetch_stage;
    import fetch_pkg::*;

    localparam logic [31:0] N  = 32'h0000_0013;
    localparam logic [31:0] W0 = 32'h0000_0093;
    localparam logic [31:0] W1 = 32'h0010_0113;
    localparam logic [31:0] W2 = 32'h0020_0193;
    localparam logic [31:0] W3 = 32'h0030_0213;
    localparam logic [31:0] WA = 32'h00A0_0093;
    localparam logic [31:0] WB = 32'hBAD0_0093;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fetch_stage_if bus();

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (32'h0000_0013)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        chk;
        logic        rst_in;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        ready;
        logic        rvalid;
        logic [31:0] rdata;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evalid;
        logic [31:0] einst;
        logic [31:0] epc;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic c, input logic r, input logic st, input logic rd,
                                input logic [31:0] rpc, input logic rdy, input logic rv,
                                input logic [31:0] rdat, input logic ereq, input logic [31:0] ea,
                                input logic ev, input logic [31:0] ei, input logic [31:0] ep);
        vec_t v;
        v.chk = c; v.rst_in = r; v.stall = st; v.redir = rd; v.rpc = rpc;
        v.ready = rdy; v.rvalid = rv; v.rdata = rdat;
        v.ereq = ereq; v.eaddr = ea; v.evalid = ev; v.einst = ei; v.epc = ep;
        return v;
    endfunction

    // Checked row: expected outputs seen this cycle, then the inputs driven for it.
    task automatic row(input logic st, input logic rd, input logic [31:0] rpc, input logic rdy,
                       input logic rv, input logic [31:0] rdat, input logic ereq,
                       input logic [31:0] ea, input logic ev, input logic [31:0] ei,
                       input logic [31:0] ep);
        tbl.push_back(mk(1'b1, 1'b1, st, rd, rpc, rdy, rv, rdat, ereq, ea, ev, ei, ep));
    endtask

    task automatic rst_row();
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, N, 32'h0));
    endtask

    // Called on a falling edge: check, drive, advance one cycle.
    task automatic apply_row(input vec_t v, input string tag);
        if (v.chk) begin
            chk({tag, " imem_req"},  {31'b0, bus.imem_req},  {31'b0, v.ereq});
            chk({tag, " imem_addr"}, bus.imem_addr,          v.eaddr);
            chk({tag, " out_valid"}, {31'b0, bus.out_valid}, {31'b0, v.evalid});
            chk({tag, " out_inst"},  bus.out_inst,           v.einst);
            chk({tag, " out_P_PC"},  bus.out_P_PC,           v.epc);
        end
        rst              = v.rst_in;
        bus.stall        = v.stall;
        bus.redirect     = v.redir;
        bus.redirect_pc  = v.rpc;
        bus.imem_ready   = v.ready;
        bus.imem_rvalid  = v.rvalid;
        bus.imem_rdata   = v.rdata;
        @(negedge clk);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        h = (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
        return h;
    endfunction

    // Reference model state: transaction view of the fetch stage.
    logic        m_started, m_out, m_kill, m_buf_v;
    logic [31:0] m_pc, m_buf;
    logic        o_valid;
    logic [31:0] o_inst, o_pc;
    logic        mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;

    initial begin
        bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'h0;
        bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
        repeat (2) @(negedge clk);

        // Zero-wait memory: 0, 4, 8 fetched, valid every other cycle.
        rst_row();
        row(0,0,0, 1,0,0,  0,32'h0,0,N,32'h0);
        row(0,0,0, 1,0,0,  1,32'h0,0,N,32'h0);
        row(0,0,0, 1,1,W0, 0,32'h0,0,N,32'h0);
        row(0,0,0, 1,0,0,  1,32'h4,1,W0,32'h0);
        row(0,0,0, 1,1,W1, 0,32'h4,0,N,32'h0);
        row(0,0,0, 1,0,0,  1,32'h8,1,W1,32'h4);
        row(0,0,0, 1,1,W2, 0,32'h8,0,N,32'h0);
        row(0,0,0, 0,0,0,  1,32'hC,1,W2,32'h8);

        // Stall across response at PC 4: IF/ID frozen, then delivered from HOLD.
        rst_row();
        row(0,0,0, 1,0,0,  0,32'h0,0,N,32'h0);
        row(0,0,0, 1,0,0,  1,32'h0,0,N,32'h0);
        row(0,0,0, 1,1,W3, 0,32'h0,0,N,32'h0);
        row(1,0,0, 1,0,0,  1,32'h4,1,W3,32'h0);
        row(1,0,0, 0,1,WA, 0,32'h4,1,W3,32'h0);
        row(1,0,0, 0,0,0,  0,32'h4,1,W3,32'h0);
        row(1,0,0, 0,0,0,  0,32'h4,1,W3,32'h0);
        row(0,0,0, 0,0,0,  0,32'h4,1,W3,32'h0);
        row(0,0,0, 0,0,0,  1,32'h8,1,WA,32'h4);
        row(0,0,0, 0,0,0,  1,32'h8,0,N,32'h0);

        // Redirect in WAIT without response: late response swallowed, refetch at 0x100.
        rst_row();
        row(0,0,0,          1,0,0,  0,32'h0,0,N,32'h0);
        row(0,0,0,          1,0,0,  1,32'h0,0,N,32'h0);
        row(0,1,32'h100,    1,0,0,  0,32'h0,0,N,32'h0);
        row(0,0,0,          1,0,0,  0,32'h100,0,N,32'h0);
        row(0,0,0,          1,1,WB, 0,32'h100,0,N,32'h0);
        row(0,0,0,          1,0,0,  1,32'h100,0,N,32'h0);
        row(0,0,0,          1,1,W1, 0,32'h100,0,N,32'h0);
        row(0,0,0,          0,0,0,  1,32'h104,1,W1,32'h100);

        // Redirect and response in the same WAIT cycle: old data dropped.
        rst_row();
        row(0,0,0,          1,0,0,  0,32'h0,0,N,32'h0);
        row(0,0,0,          1,0,0,  1,32'h0,0,N,32'h0);
        row(0,1,32'h100,    1,1,WB, 0,32'h0,0,N,32'h0);
        row(0,0,0,          1,0,0,  1,32'h100,0,N,32'h0);
        row(0,0,0,          1,1,W2, 0,32'h100,0,N,32'h0);
        row(0,0,0,          0,0,0,  1,32'h104,1,W2,32'h100);

        // Redirect together with stall flushes IF/ID; low target bits ignored.
        rst_row();
        row(0,0,0,          1,0,0,  0,32'h0,0,N,32'h0);
        row(0,0,0,          1,0,0,  1,32'h0,0,N,32'h0);
        row(0,0,0,          1,1,W0, 0,32'h0,0,N,32'h0);
        row(1,0,0,          0,0,0,  1,32'h4,1,W0,32'h0);
        row(1,1,32'h103,    0,0,0,  1,32'h4,1,W0,32'h0);
        row(0,0,0,          1,0,0,  1,32'h100,0,N,32'h0);
        row(0,0,0,          1,1,W1, 0,32'h100,0,N,32'h0);
        row(0,0,0,          0,0,0,  1,32'h104,1,W1,32'h100);

        // Redirect while a REQ is accepted: that request's response is killed.
        rst_row();
        row(0,0,0,          1,0,0,  0,32'h0,0,N,32'h0);
        row(0,1,32'h40,     1,0,0,  1,32'h0,0,N,32'h0);
        row(0,0,0,          1,0,0,  0,32'h40,0,N,32'h0);
        row(0,0,0,          1,1,WB, 0,32'h40,0,N,32'h0);
        row(0,0,0,          1,0,0,  1,32'h40,0,N,32'h0);
        row(0,0,0,          1,1,W2, 0,32'h40,0,N,32'h0);
        row(0,0,0,          0,0,0,  1,32'h44,1,W2,32'h40);

        // PC wrap from 0xFFFFFFFC to 0.
        rst_row();
        row(0,0,0,             0,0,0,  0,32'h0,0,N,32'h0);
        row(0,1,32'hFFFF_FFFF, 0,0,0,  1,32'h0,0,N,32'h0);
        row(0,0,0,             1,0,0,  1,32'hFFFF_FFFC,0,N,32'h0);
        row(0,0,0,             1,1,W3, 0,32'hFFFF_FFFC,0,N,32'h0);
        row(0,0,0,             0,0,0,  1,32'h0,1,W3,32'hFFFF_FFFC);
        row(0,0,0,             0,0,0,  1,32'h0,0,N,32'h0);

        foreach (tbl[i]) apply_row(tbl[i], $sformatf("vec%0d", i));

        // Asynchronous reset in WAIT with a valid IF/ID, then stale responses.
        apply_row(mk(0,0, 0,0,0, 0,0,0,  0,32'h0,0,N,32'h0), "async");
        apply_row(mk(1,1, 0,0,0, 1,0,0,  0,32'h0,0,N,32'h0), "async");
        apply_row(mk(1,1, 0,0,0, 1,0,0,  1,32'h0,0,N,32'h0), "async");
        apply_row(mk(1,1, 0,0,0, 0,1,W0, 0,32'h0,0,N,32'h0), "async");
        apply_row(mk(1,1, 1,0,0, 1,0,0,  1,32'h4,1,W0,32'h0), "async");
        chk("pre-reset out_valid", {31'b0, bus.out_valid}, 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("async imem_req",  {31'b0, bus.imem_req},  32'h0);
        chk("async imem_addr", bus.imem_addr,          32'h0);
        chk("async out_valid", {31'b0, bus.out_valid}, 32'h0);
        chk("async out_inst",  bus.out_inst,           N);
        chk("async out_P_PC",  bus.out_P_PC,           32'h0);
        @(negedge clk);
        apply_row(mk(1,1, 0,0,0, 0,1,WB, 0,32'h0,0,N,32'h0), "stale");
        apply_row(mk(1,1, 0,0,0, 0,1,WB, 1,32'h0,0,N,32'h0), "stale");
        apply_row(mk(1,1, 0,0,0, 1,0,0,  1,32'h0,0,N,32'h0), "stale");
        apply_row(mk(1,1, 0,0,0, 0,1,W1, 0,32'h0,0,N,32'h0), "stale");
        apply_row(mk(1,1, 0,0,0, 0,0,0,  1,32'h4,1,W1,32'h0), "stale");

        // Random traffic against the reference model and a legal memory.
        rst = 1'b0;
        bus.stall = 1'b0; bus.redirect = 1'b0; bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b0;
        @(negedge clk);
        m_started = 1'b0; m_out = 1'b0; m_kill = 1'b0; m_buf_v = 1'b0;
        m_pc = 32'h0; m_buf = 32'h0;
        o_valid = 1'b0; o_inst = N; o_pc = 32'h0;
        mem_busy = 1'b0; mem_cnt = 0; mem_addr = 32'h0;
        rst = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            logic st, rd, rdy, rv, acc, dl, m_req;
            logic [31:0] rpc, tgt, rdat, dl_inst;
            m_req = m_started && !m_out && !m_buf_v;
            chk("rnd imem_req",  {31'b0, bus.imem_req},  {31'b0, m_req});
            chk("rnd imem_addr", bus.imem_addr,          m_pc);
            chk("rnd out_valid", {31'b0, bus.out_valid}, {31'b0, o_valid});
            chk("rnd out_inst",  bus.out_inst,           o_inst);
            chk("rnd out_P_PC",  bus.out_P_PC,           o_pc);

            st   = ($urandom % 4) == 0;
            rd   = ($urandom % 8) == 0;
            rpc  = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
            rdy  = ($urandom % 3) != 0;
            rv   = mem_busy && (mem_cnt == 0);
            rdat = rv ? mem_word(mem_addr) : $urandom;
            tgt  = {rpc[31:2], 2'b00};
            bus.stall = st; bus.redirect = rd; bus.redirect_pc = rpc;
            bus.imem_ready = rdy; bus.imem_rvalid = rv; bus.imem_rdata = rdat;
            acc = bus.imem_req && rdy;

            dl = 1'b0; dl_inst = 32'h0;
            if (!m_started) begin
                m_started = 1'b1;
                if (rd) m_pc = tgt;
            end else if (m_buf_v) begin
                if (rd) begin
                    m_buf_v = 1'b0; m_pc = tgt;
                end else if (!st) begin
                    dl = 1'b1; dl_inst = m_buf; m_buf_v = 1'b0;
                end
            end else if (m_out) begin
                if (rv) begin
                    m_out = 1'b0;
                    if (!m_kill && !rd) begin
                        if (st) begin
                            m_buf_v = 1'b1; m_buf = rdat;
                        end else begin
                            dl = 1'b1; dl_inst = rdat;
                        end
                    end
                end
                if (rd) begin
                    m_pc = tgt;
                    if (!rv) m_kill = 1'b1;
                end
            end else begin
                if (rd) begin
                    m_pc = tgt;
                    if (rdy) begin m_out = 1'b1; m_kill = 1'b1; end
                end else if (rdy) begin
                    m_out = 1'b1; m_kill = 1'b0;
                end
            end

            if (rd) begin
                o_valid = 1'b0; o_inst = N; o_pc = 32'h0;
            end else if (st) begin
                o_valid = o_valid;
            end else if (dl) begin
                o_valid = 1'b1; o_inst = dl_inst; o_pc = m_pc; m_pc = m_pc + 32'd4;
            end else begin
                o_valid = 1'b0; o_inst = N; o_pc = 32'h0;
            end

            if (rv) mem_busy = 1'b0;
            else if (mem_busy) mem_cnt--;
            if (acc) begin
                mem_busy = 1'b1; mem_cnt = $urandom_range(0, 2); mem_addr = bus.imem_addr;
            end
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the IF/ID register consumer (decode), which feeds the ID/EX pipeline register.
- Owns the PC and issues single-outstanding requests to instruction memory with a ready/rvalid handshake.
- Holds the IF/ID register (out_P_PC, out_inst, out_valid) under stall, and flushes it to NOP on redirect from EX (branch/jump).

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- NOP_INST, 32'h0000_0013, instruction word (addi x0,x0,0) injected on flush/bubble.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  hazard unit: hold IF/ID contents and do not deliver.
- redirect  in  1  EX resolved taken branch/jump; flush and refetch.
- redirect_pc  in  32  target PC, valid when redirect=1.
- imem_req  out  1  request valid.
- imem_addr  out  32  request address (word aligned).
- imem_ready  in  1  memory accepts request this cycle (imem_req && imem_ready).
- imem_rvalid  in  1  response valid, exactly one per accepted request, at least 1 cycle after accept.
- imem_rdata  in  32  instruction word.
- out_P_PC  out  32  PC of instruction in IF/ID.
- out_inst  out  32  instruction in IF/ID.
- out_valid  out  1  IF/ID holds a real instruction (0 = bubble/NOP).

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, state=IDLE, out_P_PC=0, out_inst=NOP_INST, out_valid=0, hold buffer empty. imem_req=0 while in reset and in IDLE.
- Outputs: imem_req=1 iff state==REQ; imem_addr=pc (registered value, stable while REQ).
- FSM states: IDLE, REQ, WAIT, HOLD, KILL.
- IDLE -> REQ unconditionally one cycle after reset release.
- REQ:
  - redirect=1: pc<=redirect_pc. If imem_ready is also 1, the accepted request is wrong-path: go KILL. Otherwise stay REQ.
  - Else, imem_ready=1: go WAIT.
- WAIT:
  - redirect=1: pc<=redirect_pc. If imem_rvalid is also 1, drop the response and go REQ. Otherwise go KILL.
  - Else, rvalid && !stall: deliver imem_rdata to IF/ID with out_P_PC=pc; pc<=pc+4; go REQ.
  - Else, rvalid && stall: latch imem_rdata into the hold buffer; go HOLD.
- HOLD:
  - redirect=1: discard the buffer, pc<=redirect_pc, go REQ.
  - Else, !stall: deliver the buffer with out_P_PC=pc; pc<=pc+4; go REQ.
- KILL:
  - On rvalid: discard the data and go REQ.
  - redirect in KILL: update pc and stay KILL, unless rvalid is also 1, in which case go REQ.
- IF/ID register update priority, per cycle:
  - redirect: out_inst=NOP_INST, out_valid=0, out_P_PC=0. Redirect overrides stall.
  - Else stall: hold all three outputs.
  - Else delivery: load the new instruction, out_valid=1.
  - Else: bubble, out_inst=NOP_INST, out_valid=0, out_P_PC=0.
- Latency/throughput:
  - Accept-to-IF/ID is rvalid cycle +1.
  - Peak throughput is 1 instruction per 2 cycles (single outstanding request).
- Arithmetic: pc+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 0.
- redirect_pc: bits [1:0] are forced to 0.
- Reset mid-transaction: any in-flight response arriving after reset release while in IDLE/REQ is ignored (rvalid only honoured in WAIT/KILL).

Decomposition:
- Shared package fetch_pkg:
  - state enum {IDLE, REQ, WAIT, HOLD, KILL}.
  - NOP_INST constant (shared with the ID/EX register reset value).
  - Default RESET_PC.
- One sub-module, ifid_reg: the IF/ID register with redirect/stall/load/bubble priority. The FSM and PC remain in fetch_stage.

Test Plan:
- Reset, then 0-wait memory (ready=1, rvalid the cycle after accept) -> imem_addr 0x0, 0x4, 0x8 on successive REQ cycles. out_inst/out_P_PC match each word, out_valid=1 every other cycle.
- stall=1 held 3 cycles while response 0x00A00093 arrives at PC 0x4 -> IF/ID unchanged, state HOLD. After stall drops: out_inst=0x00A00093, out_P_PC=0x4, next imem_addr=0x8.
- redirect=1, redirect_pc=0x100 in WAIT with no rvalid -> out_valid=0, out_inst=0x13. The late response is discarded (KILL). The next request address is 0x100.
- redirect and rvalid in the same WAIT cycle -> data dropped, next imem_addr=0x100, no instruction delivered from the old path.
- redirect together with stall -> IF/ID flushed to NOP (redirect wins); redirect_pc=0x103 produces imem_addr=0x100.
- rst asserted in WAIT, released, stale rvalid pulses in IDLE -> ignored. First request is RESET_PC; pc at 0xFFFFFFFC wraps to 0x0.
